// File: rtl/nfp_match_extractor.sv
// -----------------------------------------------------------------------------
// nfp_match_extractor
//
// Purpose:
//   Turns the per-beat shift-or state vector of the non-fast-pattern matcher
//   into a serial stream of match records. Every zero bit of the state vector
//   is a match; bit 8*b+k == 0 means bucket k matched with the pattern ending
//   at byte b of the beat. Each match becomes one record carrying the packet
//   byte offset of the match end and the bucket id. Records leave in ascending
//   offset order, then ascending bucket order, at most one per cycle.
//
//   An end-of-packet beat with no matches still produces exactly one record
//   (out_hit=0, out_eop=1) so the rule checker always sees packet boundaries.
//   Non-eop beats with no matches are absorbed in a single cycle, no output.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid/in_ready      state beat handshake
//   in_sop, in_eop         first / last beat of packet
//   in_data                shift-or state vector (8*NUM_BYTES bits)
//   out_valid/out_ready    match record handshake
//   out_hit                1 = match record, 0 = end-of-packet marker
//   out_offset             packet byte offset of the match end
//   out_bucket             bucket id of the match
//   out_eop                last record of the packet
// -----------------------------------------------------------------------------
module nfp_match_extractor #(
  parameter int NUM_BYTES   = 16,
  parameter int NUM_BUCKETS = 8,
  parameter int OFFSET_W    = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic                       in_sop,
  input  logic                       in_eop,
  input  logic [8*NUM_BYTES-1:0]     in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_hit,
  output logic [OFFSET_W-1:0]        out_offset,
  output logic [2:0]                 out_bucket,
  output logic                       out_eop
);

  localparam int DATA_W   = NUM_BUCKETS * NUM_BYTES;
  localparam int IDX_W    = $clog2(DATA_W);
  localparam int BYTE_W   = IDX_W - 3;
  localparam int BEAT_W   = OFFSET_W - 4;
  // Wide enough that beat_idx*NUM_BYTES + byte can never overflow before
  // the saturation check looks at it.
  localparam int SUM_W    = OFFSET_W + BYTE_W + 1;

  // ---------------------------------------------------------------------------
  // Beat register
  // ---------------------------------------------------------------------------
  logic                full;      // a beat is held and still owes output
  logic [DATA_W-1:0]   pending;   // 1 = match not yet reported
  logic [BEAT_W-1:0]   beat_idx;  // beat number within the packet
  logic                eop_q;     // held beat is the last of its packet

  // ---------------------------------------------------------------------------
  // Record selection
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0]    sel_idx;       // lowest set pending bit
  logic                any_pending;
  logic                single_left;   // selected bit is the only one left
  logic                marker;        // owe an end-of-packet marker
  logic                last_rec;      // current record finishes the beat
  logic [BYTE_W-1:0]   rec_byte;
  logic [SUM_W-1:0]    off_sum;
  logic [OFFSET_W-1:0] rec_offset;

  logic                out_hs;
  logic                last_hs;
  logic                accept;

  // Priority encoder. Scanning from the top down lets the lowest set bit be
  // the last assignment, so it wins.
  // NOTE: every signal written in an always_comb gets a default at the top;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    sel_idx = '0;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      if (pending[i]) sel_idx = IDX_W'(i);
    end
  end

  assign any_pending = |pending;
  // Clearing the lowest set bit leaves zero exactly when one bit remains.
  assign single_left = any_pending && ((pending & (pending - 1'b1)) == '0);
  assign marker      = !any_pending && eop_q;
  assign last_rec    = marker || single_left;

  // Bit index splits into byte (upper bits) and bucket (low 3 bits). The
  // marker reports the last byte of the beat.
  assign rec_byte = marker ? BYTE_W'(NUM_BYTES - 1) : sel_idx[IDX_W-1:3];

  always_comb begin
    off_sum    = SUM_W'(beat_idx) * SUM_W'(NUM_BYTES) + SUM_W'(rec_byte);
    rec_offset = off_sum[OFFSET_W-1:0];
    if (|off_sum[SUM_W-1:OFFSET_W]) rec_offset = '1;
  end

  // ---------------------------------------------------------------------------
  // Handshakes
  // ---------------------------------------------------------------------------
  assign out_valid = full && (any_pending || eop_q);
  assign out_hs    = out_valid && out_ready;
  assign last_hs   = out_hs && last_rec;

  // Reload in the same cycle the last record of the held beat leaves, so a
  // stream of beats drains without bubbles.
  assign in_ready  = !full || last_hs;
  assign accept    = in_valid && in_ready;

  // Outputs are forced to zero while idle so downstream never sees stale
  // fields; while stalled they hold because the beat register does not move.
  assign out_hit    = out_valid && !marker;
  assign out_offset = out_valid ? rec_offset : '0;
  assign out_bucket = (out_valid && !marker) ? sel_idx[2:0] : 3'd0;
  assign out_eop    = out_valid && eop_q && last_rec;

  // ---------------------------------------------------------------------------
  // State update
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  // NOTE: the pending mask is reset along with the control bits; a reset in
  // the middle of a drain must not leave stale matches to report later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full     <= 1'b0;
      pending  <= '0;
      beat_idx <= '0;
      eop_q    <= 1'b0;
    end else if (accept) begin
      // A non-eop beat with no matches owes nothing and is dropped at once.
      full    <= (~in_data != '0) || in_eop;
      pending <= ~in_data;
      eop_q   <= in_eop;
      if (in_sop) begin
        beat_idx <= '0;
      end else if (beat_idx != '1) begin
        beat_idx <= beat_idx + 1'b1;
      end
    end else if (out_hs) begin
      // Clear the reported (lowest) bit; harmless for the marker, where the
      // mask is already zero.
      pending <= pending & (pending - 1'b1);
      if (last_rec) full <= 1'b0;
    end
  end

endmodule

// File: tb/tb_nfp_match_extractor.sv
module tb_nfp_match_extractor;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_sop = 1'b0;
  logic         in_eop = 1'b0;
  logic [127:0] in_data = '1;
  logic         in_ready;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         out_hit;
  logic [15:0]  out_offset;
  logic [2:0]   out_bucket;
  logic         out_eop;

  nfp_match_extractor #(.NUM_BYTES(16), .NUM_BUCKETS(8), .OFFSET_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_sop     (in_sop),
    .in_eop     (in_eop),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_hit    (out_hit),
    .out_offset (out_offset),
    .out_bucket (out_bucket),
    .out_eop    (out_eop)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        hit;
    logic [15:0] off;
    logic [2:0]  bk;
    logic        eop;
  } rec_t;

  typedef struct {
    bit           sop;
    bit           eop;
    logic [127:0] d;
  } beat_t;

  int   total = 0;
  int   bad   = 0;
  rec_t exp_q[$];
  int   m_idx = 0;

  function automatic rec_t mk(bit h, int off, int bk, bit e);
    rec_t r;
    r.hit = h;
    r.off = off[15:0];
    r.bk  = bk[2:0];
    r.eop = e;
    return r;
  endfunction

  function automatic rec_t obs();
    return {out_hit, out_offset, out_bucket, out_eop};
  endfunction

  // Reference model: list every zero bit as (byte, bucket) in byte-major
  // order; the packet offset is beat number * 16 + byte.
  task automatic model_beat(bit sop, bit eop, logic [127:0] d);
    int   n0;
    int   off;
    rec_t r;
    if (sop) m_idx = 0;
    else if (m_idx < 4095) m_idx = m_idx + 1;
    n0 = exp_q.size();
    for (int b = 0; b < 16; b++) begin
      for (int k = 0; k < 8; k++) begin
        if (d[8*b+k] == 1'b0) begin
          off = m_idx * 16 + b;
          if (off > 65535) off = 65535;
          exp_q.push_back(mk(1'b1, off, k, 1'b0));
        end
      end
    end
    if (eop) begin
      if (exp_q.size() > n0) begin
        r = exp_q.pop_back();
        r.eop = 1'b1;
        exp_q.push_back(r);
      end else begin
        exp_q.push_back(mk(1'b0, m_idx * 16 + 15, 0, 1'b1));
      end
    end
  endtask

  task automatic drive(bit sop, bit eop, logic [127:0] d);
    @(negedge clk);
    in_valid = 1'b1;
    in_sop   = sop;
    in_eop   = eop;
    in_data  = d;
  endtask

  task automatic idle_neg();
    @(negedge clk);
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    total++;
    if ({out_valid, in_ready, obs()} !== {1'b0, 1'b1, 21'd0}) begin
      bad++;
      $display("FAIL reset_active: got v=%0b rdy=%0b rec=%h want v=0 rdy=1 rec=0", out_valid, in_ready, obs());
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    total++;
    if ({out_valid, in_ready, obs()} !== {1'b0, 1'b1, 21'd0}) begin
      bad++;
      $display("FAIL reset_release: got v=%0b rdy=%0b rec=%h want v=0 rdy=1 rec=0", out_valid, in_ready, obs());
    end
  endtask

  task automatic test_single_match();
    logic [127:0] d;
    d = '1;
    d[8'h1A] = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, 1'b0, d);
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL single_accept: got rdy=%0b want 1", in_ready);
    end
    idle_neg();
    #1;
    total++;
    if ({out_valid, obs()} !== {1'b1, mk(1'b1, 3, 2, 1'b0)}) begin
      bad++;
      $display("FAIL single_rec: got v=%0b rec=%h want v=1 rec=%h", out_valid, obs(), mk(1'b1, 3, 2, 1'b0));
    end
    idle_neg();
    #1;
    total++;
    if ({out_valid, in_ready} !== 2'b01) begin
      bad++;
      $display("FAIL single_after: got v=%0b rdy=%0b want v=0 rdy=1", out_valid, in_ready);
    end
  endtask

  task automatic test_three_beat();
    logic [127:0] d;
    d = '1;
    d[5] = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, 1'b0, '1);
    drive(1'b0, 1'b0, '1);
    #1;
    total++;
    if ({out_valid, in_ready} !== 2'b01) begin
      bad++;
      $display("FAIL three_beat0: got v=%0b rdy=%0b want v=0 rdy=1", out_valid, in_ready);
    end
    drive(1'b0, 1'b1, d);
    #1;
    total++;
    if ({out_valid, in_ready} !== 2'b01) begin
      bad++;
      $display("FAIL three_beat1: got v=%0b rdy=%0b want v=0 rdy=1", out_valid, in_ready);
    end
    idle_neg();
    #1;
    total++;
    if ({out_valid, obs()} !== {1'b1, mk(1'b1, 32, 5, 1'b1)}) begin
      bad++;
      $display("FAIL three_rec: got v=%0b rec=%h want v=1 rec=%h", out_valid, obs(), mk(1'b1, 32, 5, 1'b1));
    end
    idle_neg();
    #1;
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL three_after: got v=%0b want 0", out_valid);
    end
  endtask

  task automatic test_marker();
    out_ready = 1'b1;
    drive(1'b1, 1'b0, '1);
    drive(1'b0, 1'b1, '1);
    idle_neg();
    #1;
    total++;
    if ({out_valid, obs()} !== {1'b1, mk(1'b0, 31, 0, 1'b1)}) begin
      bad++;
      $display("FAIL marker_rec: got v=%0b rec=%h want v=1 rec=%h", out_valid, obs(), mk(1'b0, 31, 0, 1'b1));
    end
    idle_neg();
    #1;
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL marker_once: got v=%0b want 0", out_valid);
    end
  endtask

  task automatic test_stall();
    logic [127:0] d;
    d = '1;
    d[9] = 1'b0;
    d[8] = 1'b0;
    out_ready = 1'b0;
    drive(1'b1, 1'b0, d);
    drive(1'b0, 1'b1, '1);  // held upstream until the beat drains
    #1;
    total++;
    if ({out_valid, in_ready, obs()} !== {1'b1, 1'b0, mk(1'b1, 1, 0, 1'b0)}) begin
      bad++;
      $display("FAIL stall_first: got v=%0b rdy=%0b rec=%h want v=1 rdy=0 rec=%h", out_valid, in_ready, obs(), mk(1'b1, 1, 0, 1'b0));
    end
    @(negedge clk);
    #1;
    total++;
    if ({out_valid, in_ready, obs()} !== {1'b1, 1'b0, mk(1'b1, 1, 0, 1'b0)}) begin
      bad++;
      $display("FAIL stall_hold: got v=%0b rdy=%0b rec=%h want v=1 rdy=0 rec=%h", out_valid, in_ready, obs(), mk(1'b1, 1, 0, 1'b0));
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    total++;
    if ({out_valid, in_ready, obs()} !== {1'b1, 1'b0, mk(1'b1, 1, 0, 1'b0)}) begin
      bad++;
      $display("FAIL stall_hs1: got v=%0b rdy=%0b rec=%h want v=1 rdy=0 rec=%h", out_valid, in_ready, obs(), mk(1'b1, 1, 0, 1'b0));
    end
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    total++;
    if ({out_valid, in_ready, obs()} !== {1'b1, 1'b0, mk(1'b1, 1, 1, 1'b0)}) begin
      bad++;
      $display("FAIL stall_second: got v=%0b rdy=%0b rec=%h want v=1 rdy=0 rec=%h", out_valid, in_ready, obs(), mk(1'b1, 1, 1, 1'b0));
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    total++;
    if ({out_valid, in_ready, obs()} !== {1'b1, 1'b1, mk(1'b1, 1, 1, 1'b0)}) begin
      bad++;
      $display("FAIL stall_hs2: got v=%0b rdy=%0b rec=%h want v=1 rdy=1 rec=%h", out_valid, in_ready, obs(), mk(1'b1, 1, 1, 1'b0));
    end
    idle_neg();
    #1;
    total++;
    if ({out_valid, obs()} !== {1'b1, mk(1'b0, 31, 0, 1'b1)}) begin
      bad++;
      $display("FAIL stall_held_beat: got v=%0b rec=%h want v=1 rec=%h", out_valid, obs(), mk(1'b0, 31, 0, 1'b1));
    end
    idle_neg();
  endtask

  task automatic test_all_zero();
    logic [127:0] d;
    d = '1;
    d[0] = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, 1'b1, '0);
    for (int n = 0; n < 128; n++) begin
      @(negedge clk);
      if (n == 127) begin
        in_valid = 1'b1;
        in_sop   = 1'b1;
        in_eop   = 1'b1;
        in_data  = d;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      total++;
      if ({out_valid, obs()} !== {1'b1, mk(1'b1, n / 8, n % 8, n == 127)}) begin
        bad++;
        $display("FAIL all_zero_rec%0d: got v=%0b rec=%h want v=1 rec=%h", n, out_valid, obs(), mk(1'b1, n / 8, n % 8, n == 127));
      end
      if (n == 127) begin
        total++;
        if (in_ready !== 1'b1) begin
          bad++;
          $display("FAIL all_zero_reload: got rdy=%0b want 1", in_ready);
        end
      end
    end
    idle_neg();
    #1;
    total++;
    if ({out_valid, obs()} !== {1'b1, mk(1'b1, 0, 0, 1'b1)}) begin
      bad++;
      $display("FAIL all_zero_next: got v=%0b rec=%h want v=1 rec=%h", out_valid, obs(), mk(1'b1, 0, 0, 1'b1));
    end
    idle_neg();
  endtask

  task automatic test_reset_mid_drain();
    logic [127:0] d;
    logic [127:0] d2;
    d = '1;
    d[9:0] = '0;
    d2 = '1;
    d2[20] = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 1'b0, '1);  // advance the counter so a stale value would show
    drive(1'b0, 1'b0, d);
    for (int i = 0; i < 5; i++) begin
      idle_neg();
      #1;
      total++;
      if ({out_valid, obs()} !== {1'b1, mk(1'b1, (m_idx + 2) * 16 + i / 8, i % 8, 1'b0)}) begin
        bad++;
        $display("FAIL mid_drain_rec%0d: got v=%0b rec=%h want v=1 rec=%h", i, out_valid, obs(), mk(1'b1, (m_idx + 2) * 16 + i / 8, i % 8, 1'b0));
      end
    end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({out_valid, in_ready, obs()} !== {1'b0, 1'b1, 21'd0}) begin
      bad++;
      $display("FAIL mid_drain_reset: got v=%0b rdy=%0b rec=%h want v=0 rdy=1 rec=0", out_valid, in_ready, obs());
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 1'b1, d2);
    idle_neg();
    #1;
    total++;
    if ({out_valid, obs()} !== {1'b1, mk(1'b1, 2, 4, 1'b1)}) begin
      bad++;
      $display("FAIL mid_drain_fresh: got v=%0b rec=%h want v=1 rec=%h", out_valid, obs(), mk(1'b1, 2, 4, 1'b1));
    end
    idle_neg();
    #1;
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL mid_drain_stale: got v=%0b want 0", out_valid);
    end
  endtask

  task automatic test_saturation();
    out_ready = 1'b1;
    drive(1'b1, 1'b0, '1);
    repeat (4100) drive(1'b0, 1'b0, '1);
    drive(1'b0, 1'b1, '1);
    idle_neg();
    #1;
    total++;
    if ({out_valid, obs()} !== {1'b1, mk(1'b0, 65535, 0, 1'b1)}) begin
      bad++;
      $display("FAIL saturate: got v=%0b rec=%h want v=1 rec=%h", out_valid, obs(), mk(1'b0, 65535, 0, 1'b1));
    end
    idle_neg();
  endtask

  task automatic test_random();
    beat_t tx_q[$];
    beat_t bt;
    rec_t  r;
    int    len;
    int    nz;
    bit    done;
    exp_q.delete();
    m_idx = 0;
    while (tx_q.size() < 60) begin
      len = $urandom_range(1, 4);
      for (int j = 0; j < len; j++) begin
        bt.sop = (j == 0);
        bt.eop = (j == len - 1);
        bt.d   = '1;
        if ($urandom_range(0, 9) == 0) begin
          bt.d = '0;
        end else begin
          nz = $urandom_range(0, 3);
          for (int z = 0; z < nz; z++) bt.d[$urandom_range(0, 127)] = 1'b0;
        end
        tx_q.push_back(bt);
        model_beat(bt.sop, bt.eop, bt.d);
      end
    end
    done = 1'b0;
    for (int cyc = 0; cyc < 20000 && !done; cyc++) begin
      @(negedge clk);
      out_ready = ($urandom_range(0, 3) != 0);
      if (tx_q.size() > 0) begin
        in_valid = 1'b1;
        in_sop   = tx_q[0].sop;
        in_eop   = tx_q[0].eop;
        in_data  = tx_q[0].d;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid && out_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL random_extra: got rec=%h want none", obs());
        end else begin
          r = exp_q.pop_front();
          if (obs() !== r) begin
            bad++;
            $display("FAIL random_rec: got rec=%h want rec=%h", obs(), r);
          end
        end
      end
      if (in_valid && in_ready) void'(tx_q.pop_front());
      if (tx_q.size() == 0 && exp_q.size() == 0) done = 1'b1;
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL random_timeout: got %0d beats %0d records left want 0 0", tx_q.size(), exp_q.size());
    end
    idle_neg();
    #1;
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL random_tail: got v=%0b want 0", out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_single_match();
    test_three_beat();
    test_marker();
    test_stall();
    test_all_zero();
    test_reset_mid_drain();
    test_saturation();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
